bf16_result_buffer: RTL and testbench

- Downstream stage of the bf16 adder (`fpadd`). Captures each accepted 16-bit result and its overflow flag, and classifies the value as zero, subnormal, normal, infinity or NaN.
- Queues entries in a small FIFO and presents them on a valid/ready interface to the consumer, such as a writeback or accumulator stage.
- Keeps sticky status flags and a saturating overflow-event counter for software/debug readback.

---
 rtl/bf16_result_buffer.sv | 130 +++++++++++++
 tb/tb_bf16_result_buffer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bf16_result_buffer.sv
// Result FIFO behind the bf16 adder: classifies each accepted result, queues it, and keeps sticky status.
// Optional macro BF16_RESULT_BUFFER_CANON_NAN_EN stores every pushed NaN as canonical quiet NaN 16'h7FC0.
module bf16_result_buffer #(
  parameter int DEPTH   = 4,
  parameter int COUNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_res,
  input  logic                     in_ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_res,
  output logic                     out_ovf,
  output logic [2:0]               out_class,
  output logic [$clog2(DEPTH):0]   level,
  output logic [COUNT_W-1:0]       ovf_count,
  output logic                     sticky_nan,
  output logic                     sticky_ovf,
  input  logic                     clr_status
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0]      FULL_LEVEL = LW'(DEPTH);
  localparam logic [COUNT_W-1:0] COUNT_MAX  = '1;

  localparam logic [2:0] CLS_ZERO = 3'd0;
  localparam logic [2:0] CLS_SUB  = 3'd1;
  localparam logic [2:0] CLS_NORM = 3'd2;
  localparam logic [2:0] CLS_INF  = 3'd3;
  localparam logic [2:0] CLS_NAN  = 3'd4;

  logic [15:0]   mem_res [DEPTH];
  logic          mem_ovf [DEPTH];
  logic [2:0]    mem_cls [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [2:0]    in_class;
  logic [15:0]   store_res;

  function automatic logic [2:0] classify(input logic [15:0] v);
    logic [7:0] e;
    logic [6:0] m;
    e = v[14:7];
    m = v[6:0];
    if (e == 8'h00)      return (m == 7'd0) ? CLS_ZERO : CLS_SUB;
    else if (e == 8'hFF) return (m == 7'd0) ? CLS_INF  : CLS_NAN;
    else                 return CLS_NORM;
  endfunction

  assign full      = (level == FULL_LEVEL);
  assign empty     = (level == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign in_class  = classify(in_res);

`ifdef BF16_RESULT_BUFFER_CANON_NAN_EN
  assign store_res = (in_class == CLS_NAN) ? 16'h7FC0 : in_res;
`else
  assign store_res = in_res;
`endif

  // Empty buffer reads as all-zero so the consumer never sees stale storage.
  assign out_res   = empty ? 16'h0000 : mem_res[rd_ptr];
  assign out_ovf   = empty ? 1'b0     : mem_ovf[rd_ptr];
  assign out_class = empty ? 3'd0     : mem_cls[rd_ptr];

  // NOTE: storage has no reset; contents are meaningless until the pointers
  // say otherwise, so resetting them would only cost reset routing.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_res[wr_ptr] <= store_res;
      mem_ovf[wr_ptr] <= in_ovf;
      mem_cls[wr_ptr] <= in_class;
    end
  end

  // NOTE: non-blocking assignments only in clocked blocks, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // A clear coinciding with a qualifying push still records that push.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count  <= '0;
      sticky_ovf <= 1'b0;
      sticky_nan <= 1'b0;
    end else begin
      if (clr_status) begin
        ovf_count  <= (push && in_ovf) ? COUNT_W'(1) : '0;
        sticky_ovf <= push && in_ovf;
        sticky_nan <= push && (in_class == CLS_NAN);
      end else begin
        if (push && in_ovf && (ovf_count != COUNT_MAX))
          ovf_count <= ovf_count + COUNT_W'(1);
        if (push && in_ovf)
          sticky_ovf <= 1'b1;
        if (push && (in_class == CLS_NAN))
          sticky_nan <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bf16_result_buffer.sv
// Directed self-checking bench for bf16_result_buffer (DEPTH=4, COUNT_W=8).
module tb_bf16_result_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_res;
  logic        in_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_res;
  logic        out_ovf;
  logic [2:0]  out_class;
  logic [2:0]  level;
  logic [7:0]  ovf_count;
  logic        sticky_nan;
  logic        sticky_ovf;
  logic        clr_status;

  int total = 0;
  int bad   = 0;

  bf16_result_buffer #(.DEPTH(4), .COUNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res), .in_ovf(in_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_ovf(out_ovf), .out_class(out_class), .level(level),
    .ovf_count(ovf_count), .sticky_nan(sticky_nan), .sticky_ovf(sticky_ovf),
    .clr_status(clr_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] fill_vals [4];
  logic [2:0]  fill_cls  [4];
  logic [15:0] exp_q [$];
  logic [15:0] nan_exp;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_res = '0; in_ovf = 1'b0;
    out_ready = 1'b0; clr_status = 1'b0;
    fill_vals = '{16'h0000, 16'h0001, 16'h7F80, 16'h7FE0};
    fill_cls  = '{3'd0, 3'd1, 3'd3, 3'd4};
`ifdef BF16_RESULT_BUFFER_CANON_NAN_EN
    nan_exp = 16'h7FC0;
`else
    nan_exp = 16'h7FE0;
`endif

    // Reset state
    #1; step(); step();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf_count", 32'(ovf_count), 32'd0);
    check("rst_stickies", 32'({sticky_nan, sticky_ovf}), 32'd0);
    check("rst_out_res", 32'(out_res), 32'd0);
    check("rst_out_class", 32'(out_class), 32'd0);

    // Single normal push, visible next cycle
    in_valid = 1'b1; in_res = 16'h4020; in_ovf = 1'b0;
    step();
    in_valid = 1'b0;
    check("single_out_valid", 32'(out_valid), 32'd1);
    check("single_out_res", 32'(out_res), 32'h4020);
    check("single_out_class", 32'(out_class), 32'd2);
    check("single_level", 32'(level), 32'd1);
    check("single_ovf_count", 32'(ovf_count), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("single_drained", 32'(level), 32'd0);

    // Fill to full with one value of each special class
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_res = fill_vals[i];
      step();
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_level", 32'(level), 32'd4);
    in_res = 16'hC020;
    step();
    in_valid = 1'b0;
    check("full_reject_level", 32'(level), 32'd4);
    check("full_head_stable", 32'(out_res), 32'h0000);
    check("fill_sticky_nan", 32'(sticky_nan), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_res%0d", i), 32'(out_res), (i == 3) ? 32'(nan_exp) : 32'(fill_vals[i]));
      check($sformatf("drain_cls%0d", i), 32'(out_class), 32'(fill_cls[i]));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      if (i == 0) check("pop_from_full_ready", 32'(in_ready), 32'd1);
    end
    check("drain_empty", 32'(out_valid), 32'd0);

    // Level 2, then simultaneous push/pop for 6 cycles across pointer wrap
    exp_q = {};
    in_valid = 1'b1;
    in_res = 16'h3F80; exp_q.push_back(16'h3F80); step();
    in_res = 16'h4000; exp_q.push_back(16'h4000); step();
    check("pp_level_start", 32'(level), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_res = 16'h4100 + 16'(i);
      check($sformatf("pp_head%0d", i), 32'(out_res), 32'(exp_q[0]));
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(16'h4100 + 16'(i));
      check($sformatf("pp_level%0d", i), 32'(level), 32'd2);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("pp_tail%0d", i), 32'(out_res), 32'(exp_q[0]));
      step();
      void'(exp_q.pop_front());
    end
    out_ready = 1'b0;
    check("pp_empty", 32'(level), 32'd0);

    // 300 overflow pushes saturate the counter
    out_ready = 1'b1; in_valid = 1'b1; in_ovf = 1'b1; in_res = 16'h7F7F;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 253) check("sat_count_254", 32'(ovf_count), 32'd254);
    end
    in_valid = 1'b0; in_ovf = 1'b0;
    step();
    out_ready = 1'b0;
    check("sat_ovf_count", 32'(ovf_count), 32'd255);
    check("sat_sticky_ovf", 32'(sticky_ovf), 32'd1);
    check("sat_level", 32'(level), 32'd0);

    // Clear coinciding with an overflow push
    clr_status = 1'b1; in_valid = 1'b1; in_ovf = 1'b1; in_res = 16'h4020;
    step();
    clr_status = 1'b0; in_valid = 1'b0; in_ovf = 1'b0;
    check("clr_push_count", 32'(ovf_count), 32'd1);
    check("clr_push_sticky_ovf", 32'(sticky_ovf), 32'd1);
    check("clr_push_sticky_nan", 32'(sticky_nan), 32'd0);
    check("clr_keeps_fifo", 32'(level), 32'd1);
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    check("clr_only_count", 32'(ovf_count), 32'd0);
    check("clr_head_kept", 32'(out_res), 32'h4020);

    // Fill to 3, then reset with in_valid held high
    in_valid = 1'b1;
    in_res = 16'h7F81; in_ovf = 1'b1; step();
    in_res = 16'h3F80; in_ovf = 1'b0; step();
    check("prerst_level", 32'(level), 32'd3);
    check("prerst_status", 32'({sticky_nan, sticky_ovf}), 32'd3);
    rst = 1'b1; in_res = 16'h4040; in_ovf = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; in_ovf = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_ovf_count", 32'(ovf_count), 32'd0);
    check("midrst_stickies", 32'({sticky_nan, sticky_ovf}), 32'd0);
    step();
    check("midrst_nothing_stored", 32'(level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
